rms_env_cfg_master: RTL

AXI-Lite write master that configures the stereo RMS/peak envelope core: it programs alpha (offset 0x4) and the control register (offset 0x0) on request. It also switches alpha automatically between attack and release values by monitoring the envelope output stream against a threshold with hysteresis. It sits between the system control logic and the envelope core's AXI-Lite slave, and passively taps the core's AXI-Stream output.

---
 rtl/rms_env_cfg_master.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rms_env_cfg_master.sv
// AXI-Lite write master for the stereo RMS/peak envelope core: programs alpha and control
// on request, and flips alpha between attack/release values by watching the envelope tap.
module rms_env_cfg_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int ALPHA_WIDTH        = 16,
    parameter int LEVEL_WIDTH        = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ALPHA_WIDTH-1:0]        req_alpha,
    input  logic [1:0]                    req_ctrl,
    output logic                          done,
    output logic                          busy,
    input  logic                          auto_en,
    input  logic [ALPHA_WIDTH-1:0]        attack_alpha,
    input  logic [ALPHA_WIDTH-1:0]        release_alpha,
    input  logic [LEVEL_WIDTH-1:0]        threshold,
    input  logic [LEVEL_WIDTH-1:0]        hysteresis,
    input  logic [31:0]                   env_tdata,
    input  logic                          env_tvalid,
    input  logic                          env_tready,
    output logic                          auto_mode,
    output logic                          err,
    input  logic                          err_clr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [31:0]                   m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_CTRL  = '0;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_ALPHA = C_M_AXI_ADDR_WIDTH'(4);

    typedef enum logic [1:0] {S_IDLE, S_ADDR_DATA, S_RESP} state_t;

    state_t                        r_state;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]                   r_wdata;
    logic [1:0]                    r_ctrl;
    logic                          r_more;
    logic                          r_err;
    logic                          r_auto_mode;
    logic                          r_pending;

    logic [LEVEL_WIDTH-1:0] w_ch [2];
    logic [LEVEL_WIDTH-1:0] w_level;
    logic [LEVEL_WIDTH-1:0] w_release_thr;
    logic [ALPHA_WIDTH-1:0] w_auto_alpha;
    logic                   w_tap;
    logic                   w_to_attack;
    logic                   w_to_release;
    logic                   w_auto_launch;
    logic                   w_aw_ok;
    logic                   w_w_ok;
    logic                   w_b_hs;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            assign w_ch[gi] = env_tdata[16*gi +: LEVEL_WIDTH];
        end
    endgenerate

    assign w_level       = (w_ch[1] > w_ch[0]) ? w_ch[1] : w_ch[0];
    assign w_release_thr = (threshold > hysteresis) ? (threshold - hysteresis) : '0;
    assign w_tap         = auto_en & env_tvalid & env_tready;
    assign w_to_attack   = w_tap & ~r_auto_mode & (w_level >= threshold);
    assign w_to_release  = w_tap & r_auto_mode & (w_level < w_release_thr);
    assign w_auto_alpha  = r_auto_mode ? attack_alpha : release_alpha;
    // Manual requests take the slot; pending auto work simply waits for the next IDLE cycle.
    assign w_auto_launch = (r_state == S_IDLE) & ~req_valid & r_pending & auto_en;

    // A channel whose valid has already dropped counts as handshaken.
    assign w_aw_ok = ~r_awvalid | m_axi_awready;
    assign w_w_ok  = ~r_wvalid | m_axi_wready;
    assign w_b_hs  = r_bready & m_axi_bvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_ctrl    <= '0;
            r_more    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_awaddr  <= ADDR_ALPHA;
                        r_wdata   <= 32'(req_alpha);
                        r_ctrl    <= req_ctrl;
                        r_more    <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_ADDR_DATA;
                    end else if (w_auto_launch) begin
                        r_awaddr  <= ADDR_ALPHA;
                        r_wdata   <= 32'(w_auto_alpha);
                        r_more    <= 1'b0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_ADDR_DATA;
                    end
                end
                S_ADDR_DATA: begin
                    if (m_axi_awready) r_awvalid <= 1'b0;
                    if (m_axi_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (r_more) begin
                            r_more    <= 1'b0;
                            r_awaddr  <= ADDR_CTRL;
                            r_wdata   <= {30'b0, r_ctrl};
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_ADDR_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A transition seen while a write is in flight re-arms pending; the later write
    // picks up whatever mode is current when it launches.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_auto_mode <= 1'b0;
            r_pending   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_to_attack)       r_auto_mode <= 1'b1;
            else if (w_to_release) r_auto_mode <= 1'b0;

            if (!auto_en)                         r_pending <= 1'b0;
            else if (w_to_attack || w_to_release) r_pending <= 1'b1;
            else if (w_auto_launch)               r_pending <= 1'b0;

            if (w_b_hs && (m_axi_bresp != 2'b00)) r_err <= 1'b1;
            else if (err_clr)                     r_err <= 1'b0;
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_RESP) & w_b_hs & ~r_more;
    assign auto_mode     = r_auto_mode;
    assign err           = r_err;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

endmodule
